// File: rtl/fifo_control_pkg.sv
// -----------------------------------------------------------------------------
// fifo_control_pkg
// Shared constants and types for the FIFO controller slice.
//   DEFAULT_ADDR_LENGTH : default pointer width (depth = 2**ADDR_LENGTH)
//   DEFAULT_DATA_WIDTH  : default entry width ({last flag, 64-bit data})
//   fifo_flags_t        : the four registered status flags
//   flags_for()         : status flags implied by an occupancy count
// -----------------------------------------------------------------------------
package fifo_control_pkg;

  localparam int DEFAULT_ADDR_LENGTH = 5;
  localparam int DEFAULT_DATA_WIDTH  = 65;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

  // Status flags for a given occupancy; used both for the registered flags
  // and for their reset value so the two can never disagree.
  function automatic fifo_flags_t flags_for(input int unsigned count,
                                            input int unsigned depth);
    fifo_flags_t f;
    f.empty        = (count == 0);
    f.full         = (count == depth);
    f.almost_empty = (count == 1);
    f.almost_full  = (count == depth - 1);
    return f;
  endfunction

endpackage

// File: rtl/fifo_control_if.sv
// -----------------------------------------------------------------------------
// fifo_control_if
// Bundles the FIFO request/response signals.
//   master : the client - drives clear/write/read requests and write data,
//            observes head data, flags, pointers and qualified strobes.
//   slave  : the FIFO - the mirror image of master.
// -----------------------------------------------------------------------------
interface fifo_control_if
  import fifo_control_pkg::*;
#(
  parameter int ADDR_LENGTH = DEFAULT_ADDR_LENGTH,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH
) ();

  logic                   clear_in;
  logic                   wenable_in;
  logic                   renable_in;
  logic [DATA_WIDTH-1:0]  din;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   empty_out;
  logic                   full_out;
  logic                   almost_empty_out;
  logic                   almost_full_out;
  logic [ADDR_LENGTH-1:0] waddr_out;
  logic [ADDR_LENGTH-1:0] raddr_out;
  logic                   wallow_out;
  logic                   rallow_out;

  modport master (
    output clear_in, wenable_in, renable_in, din,
    input  dout, empty_out, full_out, almost_empty_out, almost_full_out,
           waddr_out, raddr_out, wallow_out, rallow_out
  );

  modport slave (
    input  clear_in, wenable_in, renable_in, din,
    output dout, empty_out, full_out, almost_empty_out, almost_full_out,
           waddr_out, raddr_out, wallow_out, rallow_out
  );

endinterface

// File: rtl/tpram.sv
// -----------------------------------------------------------------------------
// tpram
// Two-port RAM, DEPTH x DATA_WIDTH: one synchronous write port, one
// asynchronous (combinational) read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
// -----------------------------------------------------------------------------
module tpram
  import fifo_control_pkg::*;
#(
  parameter int ADDR_LENGTH = DEFAULT_ADDR_LENGTH,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_LENGTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic [ADDR_LENGTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]  rdata
);

  localparam int DEPTH = 2 ** ADDR_LENGTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; entries are only meaningful between the read
  // and write pointers, and a resettable array would not map onto RAM cells.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_control.sv
// -----------------------------------------------------------------------------
// fifo_control
// First-word-fall-through FIFO controller around a tpram storage block.
//   clk : single clock, all state changes on the rising edge
//   rst : synchronous, active-low reset (dominates everything)
//   bus : fifo_control_if.slave
//         clear_in         synchronous flush, active-high
//         wenable_in       write request, din written when not full
//         renable_in       read request, pops the head when not empty
//         dout             head entry (combinational from raddr_out)
//         empty/full/almost_empty/almost_full_out  registered status flags
//         waddr_out/raddr_out                      write / read pointers
//         wallow_out/rallow_out                    qualified strobes
// -----------------------------------------------------------------------------
module fifo_control
  import fifo_control_pkg::*;
#(
  parameter int ADDR_LENGTH = DEFAULT_ADDR_LENGTH,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  fifo_control_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_LENGTH;

  logic [ADDR_LENGTH-1:0] waddr_q;
  logic [ADDR_LENGTH-1:0] raddr_q;
  logic [ADDR_LENGTH:0]   count_q;
  logic [ADDR_LENGTH:0]   count_next;
  fifo_flags_t            flags_q;
  fifo_flags_t            flags_next;
  logic                   wallow;
  logic                   rallow;
  logic                   flush;
  logic                   mem_we;

  // Strobes are qualified against the registered flags, so a write while
  // full is dropped even if a read frees a slot in the same cycle.
  assign wallow = bus.wenable_in & ~flags_q.full;
  assign rallow = bus.renable_in & ~flags_q.empty;

  // Reset and clear share one path; clear also suppresses the RAM write so a
  // flushed cycle leaves storage untouched.
  assign flush  = ~rst | bus.clear_in;
  assign mem_we = wallow & ~flush;

  // NOTE: every combinational output is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    count_next = count_q;
    case ({wallow, rallow})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  // Flags are registered from the next-state count so they are glitch-free
  // and valid the cycle after the edge that changed occupancy.
  assign flags_next = flags_for(32'(count_next), DEPTH);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (flush) begin
      waddr_q <= '0;
      raddr_q <= '0;
      count_q <= '0;
      flags_q <= flags_for(0, DEPTH);
    end else begin
      if (wallow) waddr_q <= waddr_q + 1'b1;
      if (rallow) raddr_q <= raddr_q + 1'b1;
      count_q <= count_next;
      flags_q <= flags_next;
    end
  end

  tpram #(
    .ADDR_LENGTH (ADDR_LENGTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_tpram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (waddr_q),
    .wdata (bus.din),
    .raddr (raddr_q),
    .rdata (bus.dout)
  );

  assign bus.empty_out        = flags_q.empty;
  assign bus.full_out         = flags_q.full;
  assign bus.almost_empty_out = flags_q.almost_empty;
  assign bus.almost_full_out  = flags_q.almost_full;
  assign bus.waddr_out        = waddr_q;
  assign bus.raddr_out        = raddr_q;
  assign bus.wallow_out       = wallow;
  assign bus.rallow_out       = rallow;

endmodule

// File: tb/tb_fifo_control.sv
// -----------------------------------------------------------------------------
// tb_fifo_control
// Self-checking bench for fifo_control (ADDR_LENGTH=5, DEPTH=32). A queue
// holds the expected FIFO contents; pointers are tracked as plain integers
// modulo DEPTH. Directed sequences are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_fifo_control;
  import fifo_control_pkg::*;

  localparam int AL    = DEFAULT_ADDR_LENGTH;
  localparam int DW    = DEFAULT_DATA_WIDTH;
  localparam int DEPTH = 2 ** AL;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_control_if #(.ADDR_LENGTH(AL), .DATA_WIDTH(DW)) bus ();

  fifo_control #(.ADDR_LENGTH(AL), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] model_q [$];
  int            wptr;
  int            rptr;
  int            n_checks;
  int            n_pass;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW; i++) v[i] = 1'($urandom_range(1, 0));
    return v;
  endfunction

  task automatic check_state();
    int n;
    n = model_q.size();
    check("empty",        DW'(bus.empty_out),        DW'(n == 0));
    check("full",         DW'(bus.full_out),         DW'(n == DEPTH));
    check("almost_empty", DW'(bus.almost_empty_out), DW'(n == 1));
    check("almost_full",  DW'(bus.almost_full_out),  DW'(n == DEPTH - 1));
    check("waddr",        DW'(bus.waddr_out),        DW'(wptr));
    check("raddr",        DW'(bus.raddr_out),        DW'(rptr));
    if (n > 0) check("dout", bus.dout, model_q[0]);
  endtask

  // One clock cycle: drive at the falling edge, check strobes just after,
  // advance the model at the rising edge, check state just after that.
  task automatic step(input bit rst_v, input bit clr, input bit w,
                      input bit r, input logic [DW-1:0] d);
    bit exp_w;
    bit exp_r;
    @(negedge clk);
    rst            = rst_v;
    bus.clear_in   = clr;
    bus.wenable_in = w;
    bus.renable_in = r;
    bus.din        = d;
    #1;
    exp_w = w && (model_q.size() < DEPTH);
    exp_r = r && (model_q.size() > 0);
    check("wallow", DW'(bus.wallow_out), DW'(exp_w));
    check("rallow", DW'(bus.rallow_out), DW'(exp_r));
    @(posedge clk);
    if (!rst_v || clr) begin
      model_q.delete();
      wptr = 0;
      rptr = 0;
    end else begin
      if (exp_r) begin
        void'(model_q.pop_front());
        rptr = (rptr + 1) % DEPTH;
      end
      if (exp_w) begin
        model_q.push_back(d);
        wptr = (wptr + 1) % DEPTH;
      end
    end
    #1;
    check_state();
  endtask

  task automatic random_phase(input int cycles, input int w_pct,
                              input int r_pct, input int clr_pct);
    for (int i = 0; i < cycles; i++) begin
      step(1'b1,
           $urandom_range(99, 0) < clr_pct,
           $urandom_range(99, 0) < w_pct,
           $urandom_range(99, 0) < r_pct,
           rand_data());
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    wptr     = 0;
    rptr     = 0;
    rst            = 1'b0;
    bus.clear_in   = 1'b0;
    bus.wenable_in = 1'b0;
    bus.renable_in = 1'b0;
    bus.din        = '0;

    // Reset held four cycles, requests active to show reset dominates.
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, rand_data());

    // Three writes, three reads, ending empty.
    step(1'b1, 1'b0, 1'b1, 1'b0, DW'(1));
    step(1'b1, 1'b0, 1'b1, 1'b0, DW'(2));
    step(1'b1, 1'b0, 1'b1, 1'b0, DW'(3));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    // Read while empty is ignored, even alongside a write.
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b1, 1'b1, DW'(4));
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);

    // Fill from address 0: 31 -> almost_full, 32 -> full, 33rd dropped.
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, 1'b0, rand_data());
    step(1'b1, 1'b0, 1'b1, 1'b0, rand_data());
    // Full with both requests: only the read happens.
    step(1'b1, 1'b0, 1'b1, 1'b1, rand_data());
    // Drain completely.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b1, '0);

    // Stream 100 entries at half occupancy with concurrent reads.
    for (int i = 0; i < DEPTH / 2; i++) step(1'b1, 1'b0, 1'b1, 1'b0, rand_data());
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b1, 1'b1, rand_data());
    for (int i = 0; i < DEPTH / 2; i++) step(1'b1, 1'b0, 1'b0, 1'b1, '0);

    // Ten entries then clear (with competing requests), then write once.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b0, rand_data());
    step(1'b1, 1'b1, 1'b1, 1'b1, rand_data());
    step(1'b1, 1'b0, 1'b1, 1'b0, rand_data());
    // Ten entries then reset mid-operation, then write once.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b0, rand_data());
    step(1'b0, 1'b0, 1'b1, 1'b0, rand_data());
    step(1'b1, 1'b0, 1'b1, 1'b0, rand_data());

    // Randomized traffic: fill-biased, drain-biased, balanced with clears.
    random_phase(200, 80, 30, 0);
    random_phase(200, 30, 80, 0);
    random_phase(300, 55, 50, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
